// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO multiply/divide sequencer for the pipelined MIPS core.
// Results are computed in one step at issue and then held back for a fixed,
// counted latency so HI/LO timing matches an iterative unit.
module mdu_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   hi_p;
    logic [31:0]   lo_p;
    logic          pend_we;

    logic          accept;
    logic          is_md;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          res_we;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [31:0]   s_div;
    logic [31:0]   u_div;
    logic [31:0]   q_mag;
    logic [31:0]   r_mag;

    // Issue qualification: only a real op, not flushed, and only while idle.
    always_comb begin
        is_md  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        accept = start && !cancel && !busy && (op != OP_NONE) && (op != OP_RSVD);
        stall  = d_is_md && (busy || (accept && is_md));
    end

    // One-shot result datapath; divisors of zero are replaced by one so the
    // divider never sees zero, and the write-back is suppressed instead.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        res_hi = '0;
        res_lo = '0;
        res_we = 1'b1;
        a_mag  = A[31] ? -A : A;
        b_mag  = B[31] ? -B : B;
        s_div  = (b_mag == '0) ? 32'd1 : b_mag;
        u_div  = (B == '0) ? 32'd1 : B;
        q_mag  = a_mag / s_div;
        r_mag  = a_mag % s_div;
        case (op)
            OP_MULT:  {res_hi, res_lo} = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
            OP_MULTU: {res_hi, res_lo} = {32'd0, A} * {32'd0, B};
            OP_DIV: begin
                res_lo = (A[31] ^ B[31]) ? -q_mag : q_mag;
                res_hi = A[31] ? -r_mag : r_mag;
                res_we = (B != '0);
            end
            OP_DIVU: begin
                res_lo = A / u_div;
                res_hi = A % u_div;
                res_we = (B != '0);
            end
            default: ;
        endcase
    end

    // Sequencer FSM with counted latency, pending results and HI/LO registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            hi_p    <= '0;
            lo_p    <= '0;
            pend_we <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state <= MUL;
                                cnt   <= MUL_LOAD;
                                busy  <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                state <= DIV;
                                cnt   <= DIV_LOAD;
                                busy  <= 1'b1;
                            end
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            default: ;
                        endcase
                        if (is_md) begin
                            hi_p    <= res_hi;
                            lo_p    <= res_lo;
                            pend_we <= res_we;
                        end
                    end
                end
                MUL, DIV: begin
                    if (cnt == '0) begin
                        if (pend_we) begin
                            HI <= hi_p;
                            LO <= lo_p;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
